arm_mc_controller: RTL and testbench

Multicycle control unit for the ARM processor: a state machine that sequences the shared datapath (single memory, one ALU, instruction/data registers) across FETCH/DECODE/EXECUTE/writeback cycles, replacing the single-cycle decode path. It also holds the NZCV flags register and condition checking, and gates every architectural write by the instruction's condition. It sits between the instruction register fields and the datapath mux selects and enables.

---
 rtl/arm_mc_pkg.sv | 48 ++++
 rtl/arm_cond_unit.sv | 74 +++++++
 rtl/arm_mc_controller.sv | 162 ++++++++++++++++
 tb/tb_arm_mc_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the ARM multicycle controller.
// State enum, ALU opcodes, condition codes and datapath select values.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_ROR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flags register and condition evaluation.
// CondExR is captured in DECODE and gates all writes of that instruction.
module arm_cond_unit
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       CondLatch,
    output logic       CondExR,
    output logic [3:0] Flags
);

    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;
    logic       cond_ex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Evaluate the condition field against the registered flags.
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    // Next flags and latched condition; flag writes need a passing condition.
    always_comb begin
        flags_d  = flags_q;
        condex_d = condex_q;
        if (FlagW[1] && condex_q) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (FlagW[0] && condex_q) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
        if (CondLatch) begin
            condex_d = cond_ex;
        end
    end

    // Flags and CondExR registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    assign CondExR = condex_q;
    assign Flags   = flags_q;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with ALU decode.
// Drives datapath selects and condition-gated write enables.
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] Flags
);

    state_t     state_q, state_d;
    logic [2:0] alu_dec;
    logic       is_cmp;
    logic       pc_to_rd;
    logic       cond_ex_r;
    logic       cond_latch;
    logic [1:0] flag_w;
    logic       pcw, mw, rw, irw;

    assign is_cmp   = (Funct[4:1] == 4'b1010);
    assign pc_to_rd = (Rd == 4'b1111);

    // Data-processing opcode to ALU operation.
    always_comb begin
        alu_dec = ALU_ADD;
        case (Funct[4:1])
            4'b0100: alu_dec = ALU_ADD;
            4'b0010: alu_dec = ALU_SUB;
            4'b1010: alu_dec = ALU_SUB;
            4'b0001: alu_dec = ALU_XOR;
            4'b1101: alu_dec = Funct[5] ? ALU_MOV : ALU_ROR;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore controls.
    always_comb begin
        state_d    = state_q;
        pcw        = 1'b0;
        mw         = 1'b0;
        rw         = 1'b0;
        irw        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        cond_latch = 1'b0;
        flag_w     = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                irw       = 1'b1;
                pcw       = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                cond_latch = 1'b1;
                unique case (Op)
                    2'b01: state_d = S_MEMADR;
                    2'b00: state_d = Funct[5] ? S_EXECUTEI
                                              : S_EXECUTER;
                    2'b10: state_d = S_BRANCH;
                    2'b11: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mw      = cond_ex_r;
                state_d = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw        = cond_ex_r;
                pcw       = cond_ex_r & pc_to_rd;
                state_d   = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (state_q == S_EXECUTEI) ? SRCB_IMM
                                                     : SRCB_RD2;
                ALUControl = alu_dec;
                flag_w[1]  = Funct[0];
                flag_w[0]  = Funct[0] &
                             ((alu_dec == ALU_ADD) |
                              (alu_dec == ALU_SUB));
                state_d    = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                rw        = cond_ex_r;
                pcw       = cond_ex_r & pc_to_rd;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pcw       = cond_ex_r;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are squashed while reset is held so nothing half-completes.
    assign PCWrite  = pcw & ~reset;
    assign MemWrite = mw  & ~reset;
    assign RegWrite = rw  & ~reset;
    assign IRWrite  = irw & ~reset;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};

    arm_cond_unit u_cond (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .CondLatch(cond_latch),
        .CondExR  (cond_ex_r),
        .Flags    (Flags)
    );

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller.
// Walks instruction sequences cycle by cycle against hand-computed controls.
module tb_arm_mc_controller;
    import arm_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite;
    logic       AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl),
        .Flags     (Flags)
    );

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {PCWrite, MemWrite, RegWrite, IRWrite}
    function automatic logic [7:0] en();
        return {4'b0, PCWrite, MemWrite, RegWrite, IRWrite};
    endfunction

    function automatic logic [7:0] st();
        return {4'b0, dut.state_q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        Cond  = c;
        Op    = o;
        Funct = f;
        Rd    = r;
    endtask

    initial begin
        reset    = 1'b1;
        ALUFlags = 4'b0000;
        set_instr(4'hE, 2'b00, 6'b001000, 4'h3);
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",    en(), 8'h00);
        check("rst_state", st(), {4'b0, S_FETCH});
        check("rst_flags", {4'b0, Flags}, 8'h00);
        check("rst_srcb",  {6'b0, ALUSrcB}, 8'h02);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // ADD r3: FETCH, DECODE, EXECUTER, ALUWB
        check("add_c1_en",  en(), 8'h09);
        check("add_c1_srca", {7'b0, ALUSrcA}, 8'h01);
        tick();
        check("add_c2_st",  st(), {4'b0, S_DECODE});
        check("add_c2_en",  en(), 8'h00);
        check("add_c2_res", {6'b0, ResultSrc}, 8'h02);
        tick();
        check("add_c3_st",  st(), {4'b0, S_EXECUTER});
        check("add_c3_alu", {5'b0, ALUControl}, 8'h00);
        check("add_c3_srcb", {6'b0, ALUSrcB}, 8'h00);
        check("add_c3_en",  en(), 8'h00);
        tick();
        check("add_c4_st",  st(), {4'b0, S_ALUWB});
        check("add_c4_en",  en(), 8'h02);
        tick();
        check("add_next",   st(), {4'b0, S_FETCH});

        // SUBS with Z result
        set_instr(4'hE, 2'b00, 6'b000101, 4'h2);
        ALUFlags = 4'b0100;
        tick();
        tick();
        check("subs_alu",   {5'b0, ALUControl}, 8'h01);
        tick();
        check("subs_flags", {4'b0, Flags}, 8'h04);
        check("subs_en",    en(), 8'h02);
        tick();

        // BEQ taken on Z
        set_instr(4'h0, 2'b10, 6'b000000, 4'h0);
        ALUFlags = 4'b0000;
        tick();
        check("beq_imm",    {6'b0, ImmSrc}, 8'h02);
        tick();
        check("beq_st",     st(), {4'b0, S_BRANCH});
        check("beq_en",     en(), 8'h08);
        check("beq_srcb",   {6'b0, ALUSrcB}, 8'h01);
        tick();
        check("beq_next",   st(), {4'b0, S_FETCH});

        // LDR pc: 5 cycles, PC written in MEMWB
        set_instr(4'hE, 2'b01, 6'b011001, 4'hF);
        tick();
        tick();
        check("ldr_adr_st", st(), {4'b0, S_MEMADR});
        check("ldr_adr_b",  {6'b0, ALUSrcB}, 8'h01);
        tick();
        check("ldr_rd_st",  st(), {4'b0, S_MEMREAD});
        check("ldr_rd_adr", {7'b0, AdrSrc}, 8'h01);
        tick();
        check("ldr_wb_st",  st(), {4'b0, S_MEMWB});
        check("ldr_wb_res", {6'b0, ResultSrc}, 8'h01);
        check("ldr_wb_en",  en(), 8'h0A);
        tick();
        check("ldr_next",   st(), {4'b0, S_FETCH});

        // STRNE with Z set: no write
        set_instr(4'h1, 2'b01, 6'b011000, 4'h4);
        tick();
        tick();
        tick();
        check("str_st",     st(), {4'b0, S_MEMWRITE});
        check("str_en",     en(), 8'h00);
        check("str_adr",    {7'b0, AdrSrc}, 8'h01);
        check("str_regsrc", {6'b0, RegSrc}, 8'h02);
        tick();
        check("str_next",   st(), {4'b0, S_FETCH});

        // CMP: 3 cycles, all flags written
        set_instr(4'hE, 2'b00, 6'b010101, 4'h0);
        ALUFlags = 4'b1011;
        tick();
        tick();
        check("cmp_alu",    {5'b0, ALUControl}, 8'h01);
        check("cmp_en",     en(), 8'h00);
        tick();
        check("cmp_next",   st(), {4'b0, S_FETCH});
        check("cmp_flags",  {4'b0, Flags}, 8'h0B);

        // MOVS imm: only N,Z change
        set_instr(4'hE, 2'b00, 6'b111011, 4'h5);
        ALUFlags = 4'b0100;
        tick();
        tick();
        check("movs_st",    st(), {4'b0, S_EXECUTEI});
        check("movs_alu",   {5'b0, ALUControl}, 8'h04);
        check("movs_srcb",  {6'b0, ALUSrcB}, 8'h01);
        tick();
        check("movs_flags", {4'b0, Flags}, 8'h07);
        check("movs_en",    en(), 8'h02);
        tick();

        // Op=11 NOP: 2 cycles
        set_instr(4'hE, 2'b11, 6'b000000, 4'h0);
        tick();
        tick();
        check("nop_next",   st(), {4'b0, S_FETCH});

        // Reset during MEMREAD
        set_instr(4'hE, 2'b01, 6'b011001, 4'h1);
        tick();
        tick();
        tick();
        check("abort_st",   st(), {4'b0, S_MEMREAD});
        reset = 1'b1;
        #1;
        check("abort_en",   en(), 8'h00);
        check("abort_stq",  st(), {4'b0, S_FETCH});
        check("abort_flg",  {4'b0, Flags}, 8'h00);
        tick();
        check("abort_hold", en(), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_st",     st(), {4'b0, S_FETCH});
        check("rel_en",     en(), 8'h09);
        tick();
        check("rel_dec",    st(), {4'b0, S_DECODE});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
